// File: rtl/counter_cond_param.sv
// Per-channel FIFO pop counters with a registered one-shot read handshake.
// Supports wrap/saturate counting, sticky overflow, clear-on-read and global clear.
module counter_cond_param #(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned DATA_W      = 8,
  parameter bit          SATURATE    = 1'b0,
  parameter bit          CLR_ON_READ = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idle,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  input  logic [NUM_CH-1:0] fifo_pop,
  input  logic              clear_all,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              err,
  output logic [NUM_CH-1:0] overflow
);

  typedef enum logic [0:0] {StWait, StResp} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0]  ovf_q, ovf_d;
  logic [CNT_W-1:0]   resp_cnt_q, resp_cnt_d;
  logic               resp_err_q, resp_err_d;

  logic               accept;
  logic               idx_ok;
  logic [CNT_W-1:0]   sel_cnt;

  assign accept = (state_q == StWait) && idle && req;
  assign idx_ok = 32'(idx) < NUM_CH;

  always_comb begin
    sel_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) sel_cnt = cnt_q[i];
    end
  end

  // Clear-on-read zeroes the base before the pop is applied, so a same-cycle pop lands as 1.
  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_all) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else begin
        if (CLR_ON_READ && accept && idx_ok && (idx == IDX_W'(i))) begin
          cnt_d[i] = '0;
          ovf_d[i] = 1'b0;
        end
        if (fifo_pop[i]) begin
          if (cnt_d[i] == CntMax) begin
            cnt_d[i] = SATURATE ? CntMax : '0;
            ovf_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_d[i] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    resp_cnt_d = resp_cnt_q;
    resp_err_d = resp_err_q;
    unique case (state_q)
      StWait: begin
        if (accept) begin
          state_d    = StResp;
          resp_cnt_d = idx_ok ? sel_cnt : '0;
          resp_err_d = !idx_ok;
        end
      end
      StResp:  state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StWait;
      ovf_q      <= '0;
      resp_cnt_q <= '0;
      resp_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      resp_cnt_q <= resp_cnt_d;
      resp_err_q <= resp_err_d;
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign valid    = (state_q == StResp);
  assign data_out = valid ? DATA_W'(resp_cnt_q) : '0;
  assign err      = valid & resp_err_q;
  assign overflow = ovf_q;

endmodule
